// File: rtl/fp_multiply_seq.sv
// Sequential IEEE-754 single-precision multiplier.
// Zero, denormal, NaN and infinity operands resolve straight to a result.
// Normal operands use an iterative shift-add mantissa multiply, followed by
// one normalise/round cycle. Operands and results use valid/ready handshakes.
module fp_multiply_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam int N = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_COUNT = 5'(N - 1);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] fraction;
  } float_t;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    NORM,
    DONE
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;

  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [47:0]        r_mcand;
  logic [23:0]        r_mplier;
  logic [47:0]        r_acc;
  logic [4:0]         r_count;
  logic [31:0]        r_result;

  float_t             w_a;
  float_t             w_b;
  logic               w_sign;
  logic               w_aNan, w_bNan, w_aInf, w_bInf, w_aZero, w_bZero;
  logic               w_special;
  logic [31:0]        w_specialResult;
  logic signed [9:0]  w_expSum;

  logic [47:0]        w_accNext;

  logic               w_hi;
  logic [22:0]        w_fracPre;
  logic               w_guard;
  logic               w_sticky;
  logic               w_roundUp;
  logic [23:0]        w_fracRounded;
  logic [22:0]        w_fracFinal;
  logic signed [9:0]  w_expNorm;
  logic signed [9:0]  w_expFinal;
  logic [31:0]        w_normResult;

  assign w_a    = a;
  assign w_b    = b;
  assign w_sign = w_a.sign ^ w_b.sign;

  // Denormals count as zero, so a zero exponent alone marks a zero operand.
  assign w_aNan  = (w_a.exponent == 8'hFF) && (w_a.fraction != 23'h0);
  assign w_bNan  = (w_b.exponent == 8'hFF) && (w_b.fraction != 23'h0);
  assign w_aInf  = (w_a.exponent == 8'hFF) && (w_a.fraction == 23'h0);
  assign w_bInf  = (w_b.exponent == 8'hFF) && (w_b.fraction == 23'h0);
  assign w_aZero = (w_a.exponent == 8'h00);
  assign w_bZero = (w_b.exponent == 8'h00);

  assign w_special = w_aNan | w_bNan | w_aInf | w_bInf | w_aZero | w_bZero;

  // Unbiased sum of exponents, re-biased once; range needs 10 signed bits.
  assign w_expSum = $signed({2'b00, w_a.exponent}) + $signed({2'b00, w_b.exponent}) - 10'sd127;

  // Special-case result selection; NaN and inf*zero take precedence over the rest.
  always_comb begin
    w_specialResult = {w_sign, 31'h0};
    if (w_aNan || w_bNan || (w_aInf && w_bZero) || (w_bInf && w_aZero)) begin
      w_specialResult = 32'h7FC0_0000;
    end else if (w_aInf || w_bInf) begin
      w_specialResult = {w_sign, 8'hFF, 23'h0};
    end else begin
      w_specialResult = {w_sign, 31'h0};
    end
  end

  // One MULT step: add the shifted multiplicand for each retired multiplier bit.
  always_comb begin
    w_accNext = r_acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) begin
        w_accNext = w_accNext + (r_mcand << i);
      end
    end
  end

  assign w_hi      = r_acc[47];
  assign w_fracPre = w_hi ? r_acc[46:24] : r_acc[45:23];
  assign w_guard   = w_hi ? r_acc[23] : r_acc[22];
  assign w_sticky  = w_hi ? (|r_acc[22:0]) : (|r_acc[21:0]);
  assign w_expNorm = r_exp + $signed({9'd0, w_hi});

  assign w_roundUp     = w_guard & (w_sticky | w_fracPre[0]);
  assign w_fracRounded = {1'b0, w_fracPre} + {23'd0, w_roundUp};
  assign w_fracFinal   = w_fracRounded[23] ? 23'h0 : w_fracRounded[22:0];
  assign w_expFinal    = w_expNorm + $signed({9'd0, w_fracRounded[23]});

  // Final packing with overflow to infinity and underflow flushed to zero.
  always_comb begin
    w_normResult = {r_sign, w_expFinal[7:0], w_fracFinal};
    if (w_expFinal >= 10'sd255) begin
      w_normResult = {r_sign, 8'hFF, 23'h0};
    end else if (w_expFinal <= 10'sd0) begin
      w_normResult = {r_sign, 31'h0};
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and handshake outputs decoded from the current state only.
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_stateNext = w_special ? DONE : MULT;
        end
      end
      MULT: begin
        busy = 1'b1;
        if (r_count == LAST_COUNT) begin
          w_stateNext = NORM;
        end
      end
      NORM: begin
        busy        = 1'b1;
        w_stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iterations and result register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            if (w_special) begin
              r_result <= w_specialResult;
            end else begin
              r_exp    <= w_expSum;
              r_mcand  <= {24'h0, 1'b1, w_a.fraction};
              r_mplier <= {1'b1, w_b.fraction};
              r_acc    <= '0;
              r_count  <= '0;
            end
          end
        end
        MULT: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_count  <= r_count + 5'd1;
        end
        NORM: begin
          r_result <= w_normResult;
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_fp_multiply_seq.sv
// Self-checking bench for fp_multiply_seq: randomized operands compared
// against a plain-arithmetic floating-point model, plus directed vectors.
module tb_fp_multiply_seq;

  localparam int BPC         = 1;
  localparam int NCYC        = 24 / BPC;
  localparam int LAT_NORMAL  = NCYC + 2;
  localparam int LAT_SPECIAL = 1;
  localparam int RST_WAIT    = (NCYC >= 10) ? 9 : 0;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        busy;

  int          readyMode = 0;
  logic        manualReady = 1'b1;
  logic        randReady = 1'b1;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          dueCyc;
  } pend_t;

  pend_t       pending[$];
  logic [31:0] lastRes = 32'h0;
  logic        expValid;
  logic        expBusy;
  logic        expReady;

  fp_multiply_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (opA),
    .b         (opB),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  assign outReady = (readyMode == 1) ? randReady : ((readyMode == 2) ? manualReady : 1'b1);

  // Cycle counter used to time expected result arrival.
  always @(posedge clock) cyc <= cyc + 1;

  // Random consumer backpressure, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      randReady = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] fpMulModel(input logic [31:0] x, input logic [31:0] y);
    logic            s;
    int              ex, ey, e, shift;
    longint unsigned fx, fy, prod, mant, rem, half;
    bit              xNan, yNan, xInf, yInf, xZero, yZero;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = 64'(x[22:0]);
    fy = 64'(y[22:0]);
    xNan  = (ex == 255) && (fx != 0);
    yNan  = (ey == 255) && (fy != 0);
    xInf  = (ex == 255) && (fx == 0);
    yInf  = (ey == 255) && (fy == 0);
    xZero = (ex == 0);
    yZero = (ey == 0);
    if (xNan || yNan || (xInf && yZero) || (yInf && xZero)) return 32'h7FC0_0000;
    if (xInf || yInf) return {s, 8'hFF, 23'h0};
    if (xZero || yZero) return {s, 31'h0};
    prod = (fx + (64'd1 << 23)) * (fy + (64'd1 << 23));
    e = ex + ey - 127;
    if (prod >= (64'd1 << 47)) begin
      shift = 24;
      e++;
    end else begin
      shift = 23;
    end
    mant = prod >> shift;
    rem  = prod - (mant << shift);
    half = 64'd1 << (shift - 1);
    if ((rem > half) || ((rem == half) && mant[0])) mant++;
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  function automatic int modelLatency(input logic [31:0] x, input logic [31:0] y);
    if (x[30:23] == 8'h00 || x[30:23] == 8'hFF || y[30:23] == 8'h00 || y[30:23] == 8'hFF)
      return LAT_SPECIAL;
    return LAT_NORMAL;
  endfunction

  function automatic logic [31:0] randFloat();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = $urandom_range(0, 15);
    f   = 23'($urandom);
    e   = 8'($urandom_range(64, 190));
    case (sel)
      0: begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = 23'h0; end
      1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'h0; end
      2: e = 8'($urandom);
      3: f = 23'h7FFFFF;
      4: e = 8'($urandom_range(1, 20));
      5: e = 8'($urandom_range(230, 254));
      default: ;
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Compare process: checks every output each cycle against the queued model.
  always @(negedge clock) begin
    if (reset) begin
      checkBit("rst in_ready", inReady, 1'b1);
      checkBit("rst out_valid", outValid, 1'b0);
      checkBit("rst busy", busy, 1'b0);
      checkOutput("rst result", result, 32'h0);
      pending.delete();
      lastRes = 32'h0;
    end else begin
      expReady = (pending.size() == 0);
      expValid = (pending.size() != 0) && (cyc >= pending[0].dueCyc);
      expBusy  = (pending.size() != 0) && (cyc < pending[0].dueCyc);
      if (expValid) lastRes = pending[0].res;
      checkBit("in_ready", inReady, expReady);
      checkBit("out_valid", outValid, expValid);
      checkBit("busy", busy, expBusy);
      checkOutput("result", result, lastRes);
      if (expValid && outReady) void'(pending.pop_front());
      if (inValid && expReady) pending.push_back('{fpMulModel(opA, opB), cyc + modelLatency(opA, opB)});
    end
  end

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
    int   guard;
    logic took;
    guard = 0;
    took  = 1'b0;
    @(posedge clock);
    #1;
    opA     = x;
    opB     = y;
    inValid = 1'b1;
    while (!took && guard < 300) begin
      @(negedge clock);
      took = inReady;
      @(posedge clock);
      #1;
      guard++;
    end
    inValid = 1'b0;
    checkBit("accept timeout", took, 1'b1);
  endtask

  task automatic waitOutValid(output int n);
    n = 1;
    while (!outValid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkBit("out_valid timeout", outValid, 1'b1);
  endtask

  task automatic runVector(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp, input int expLat);
    int n;
    checkOutput($sformatf("model %h*%h", x, y), fpMulModel(x, y), exp);
    applyStimulus(x, y);
    waitOutValid(n);
    checkInt($sformatf("latency %h*%h", x, y), n, expLat);
    checkOutput($sformatf("dut %h*%h", x, y), result, exp);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((pending.size() != 0 || !inReady) && g < 500) begin
      @(negedge clock);
      g++;
    end
    checkBit("drain timeout", inReady, 1'b1);
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int n;
    reset   = 1'b1;
    inValid = 1'b0;
    opA     = 32'h0;
    opB     = 32'h0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    $display("[TB] directed vectors");
    readyMode = 0;
    runVector(32'h3FC00000, 32'h40000000, 32'h40400000, LAT_NORMAL);
    runVector(32'hC0400000, 32'h3F000000, 32'hBFC00000, LAT_NORMAL);
    runVector(32'h3F800001, 32'h3F800001, 32'h3F800002, LAT_NORMAL);
    runVector(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, LAT_NORMAL);
    runVector(32'h7F800000, 32'h00000000, 32'h7FC00000, LAT_SPECIAL);
    runVector(32'hFF800000, 32'h40000000, 32'hFF800000, LAT_SPECIAL);
    runVector(32'h80000000, 32'h3F800000, 32'h80000000, LAT_SPECIAL);
    runVector(32'h7FC00001, 32'h3F800000, 32'h7FC00000, LAT_SPECIAL);
    runVector(32'h00000001, 32'h40000000, 32'h00000000, LAT_SPECIAL);
    runVector(32'h7F000000, 32'h40000000, 32'h7F800000, LAT_NORMAL);
    runVector(32'h00800000, 32'h3F000000, 32'h00000000, LAT_NORMAL);
    runVector(32'h80800000, 32'h3F000000, 32'h80000000, LAT_NORMAL);
    drain();

    $display("[TB] backpressure");
    readyMode   = 2;
    manualReady = 1'b0;
    applyStimulus(32'h3FC00000, 32'h40000000);
    opA     = 32'h3F800001;
    opB     = 32'h3F800001;
    inValid = 1'b1;
    waitOutValid(n);
    repeat (5) begin
      @(negedge clock);
      checkBit("bp in_ready", inReady, 1'b0);
      checkBit("bp out_valid", outValid, 1'b1);
      checkOutput("bp result", result, 32'h40400000);
    end
    @(posedge clock);
    #1 manualReady = 1'b1;
    @(posedge clock);
    #1;
    checkBit("bp after handshake in_ready", inReady, 1'b1);
    checkBit("bp after handshake out_valid", outValid, 1'b0);
    @(posedge clock);
    #1;
    checkBit("bp pending accepted", inReady, 1'b0);
    inValid = 1'b0;
    waitOutValid(n);
    checkOutput("bp second result", result, 32'h3F800002);
    readyMode = 0;
    drain();

    $display("[TB] reset mid-operation");
    applyStimulus(32'h3FC00000, 32'h40000000);
    repeat (RST_WAIT) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkBit("async rst busy", busy, 1'b0);
    checkBit("async rst in_ready", inReady, 1'b1);
    checkOutput("async rst result", result, 32'h0);
    @(posedge clock);
    #2 reset = 1'b0;
    runVector(32'h3F800000, 32'h3F800000, 32'h3F800000, LAT_NORMAL);
    drain();

    $display("[TB] random operands");
    readyMode = 1;
    repeat (150) begin
      applyStimulus(randFloat(), randFloat());
    end
    drain();
    readyMode = 0;

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fp_multiply_seq.md
# fp_multiply_seq

Sequential IEEE-754 single-precision multiplier that consumes two `float` operands (sign/exponent/fraction packed struct, 1/8/23 bits) and returns their product as a `float`. It sits directly downstream of the floating-point package's classification helpers: zero/denorm/NaN/infinity tests select special-case results, and normal operands go through an iterative shift-add mantissa multiply. Operands and results use a valid/ready handshake so the block can sit between an operand source and a result consumer with backpressure.

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits retired per MULT cycle; legal values are 1, 2, 3, 4, 6, 8, 12 and 24. N = 24 / `BITS_PER_CYCLE`.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands `a`/`b` valid.
- `in_ready`  out  1  block can accept operands; equals (state == IDLE).
- `a`  in  32  operand A, type `float`.
- `b`  in  32  operand B, type `float`.
- `out_valid`  out  1  `result` valid; equals (state == DONE).
- `out_ready`  in  1  consumer accepts `result`.
- `result`  out  32  product, type `float`.
- `busy`  out  1  high in MULT or NORM.

## Operation
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=32'h0, all internal registers 0.
- Accept: `in_valid && in_ready` on a clock edge latches `a` and `b`. Sign = a.sign ^ b.sign.
- Special-case classification, evaluated at accept, in priority order:
  - Either operand NaN, or infinity × (zero or denorm): result 32'h7FC00000, regardless of sign.
  - Either operand infinity: {sign, 8'hFF, 23'h0}.
  - Either operand zero or denorm (denorms are flushed to zero): {sign, 31'h0}.
  - A special case goes IDLE→DONE directly.
- Normal path, IDLE→MULT:
  - Mantissas are {1, fraction}, 24 bits each.
  - Exponent = ea + eb − 127, held as a 10-bit signed value.
  - The 48-bit accumulator is cleared.
- MULT: each cycle, for each of the next `BITS_PER_CYCLE` bits of mantissa B (LSB first), add the shifted mantissa A if the bit is 1. After N cycles go to NORM.
- NORM (1 cycle):
  - Normalise: if product bit 47 = 1, use bits 46:24 as the fraction, bit 23 as guard, and OR(22:0) as sticky, and add 1 to the exponent. Otherwise use bits 45:23, guard = bit 22, sticky = OR(21:0).
  - Round to nearest even: increment if guard & (sticky | fraction LSB). If the fraction overflows on rounding, set fraction = 0 and add 1 to the exponent.
  - Exponent ≥ 255 → {sign, 8'hFF, 23'h0}. Exponent ≤ 0 → {sign, 31'h0} (flush, no denorm output).
  - Register `result`, then go to DONE.
- DONE: hold `result` and `out_valid` until `out_ready` is high, then go to IDLE. `result` keeps its value after the handshake until the next DONE entry.
- No operand is accepted in MULT, NORM or DONE (`in_ready`=0), even if `out_ready` is high in DONE.
- Reset asserted in any state forces the reset values immediately (asynchronous). The in-flight operation is discarded with no output.

## Timing
- Accept on edge T.
- Normal path: MULT cycles T+1..T+N, NORM at T+N+1, `out_valid` high from T+N+2. Latency is N+2 cycles; with default N=24 that is 26.
- Special case: `out_valid` high from T+1.
- Minimum issue interval: N+3 cycles (normal path), 2 cycles (special case), with `out_ready` held high.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `in_valid` or `out_ready`.

## Test plan
- Basic product, `BITS_PER_CYCLE`=1: 3FC00000 × 40000000 → 40400000 with `out_valid` exactly 26 cycles after accept. C0400000 × 3F000000 → BFC00000. Repeat with `BITS_PER_CYCLE`=8: same results, latency 5.
- Rounding: 3F800001 × 3F800001 → 3F800002. 3FFFFFFF × 3FFFFFFF → 407FFFFE (mantissa-overflow normalisation path).
- Specials:
  - 7F800000 × 00000000 → 7FC00000.
  - FF800000 × 40000000 → FF800000.
  - 80000000 × 3F800000 → 80000000.
  - 7FC00001 × 3F800000 → 7FC00000.
  - 00000001 × 40000000 → 00000000 (denorm flushed).
  - Each of these has latency 1.
- Overflow/underflow: 7F000000 × 40000000 → 7F800000. 00800000 × 3F000000 → 00000000. 80800000 × 3F000000 → 80000000.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises. `result` is stable, `in_ready`=0 and a pending `in_valid` is not accepted. The handshake completes on the cycle `out_ready`=1, and the next operand is accepted the following cycle.
- Reset mid-operation: assert `reset` at MULT cycle 10 for 1 cycle. Outputs return to reset values asynchronously, no `out_valid` pulse follows, and a fresh 3F800000 × 3F800000 then yields 3F800000.
